// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: shared FSM type, memory-size default and word-index helpers for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int DATA_MEM_SIZE_DEF = 64;
   localparam int WORD_LSB          = 2;

   // The full 30-bit word index is compared, so aliasing high addresses never look legal.
   function automatic logic word_in_range(input logic [31:0] addr, input int unsigned words);
      logic [31:0] idx;
      idx = addr >> WORD_LSB;
      return idx < words;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// dmem_rr_pick: 2-way round-robin selector; a non-zero owner mask restricts the grant to that port.
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_ptr,
   input  logic [1:0] owner,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (owner != 2'b00)
         gnt = req & owner;
      else if (req == 2'b11)
         gnt = rr_ptr ? 2'b10 : 2'b01;
      else
         gnt = req;
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin data-memory arbiter with bounded lock, registered read return and range check.
// Optional saturating grant/stall counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEF,
   parameter int MAX_LOCK      = 16,
   parameter int LOCK_CNT_W    = $clog2(MAX_LOCK)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   input  logic [31:0] mem_read_data,
   output logic        lock_timeout
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] grant_cnt0,
   output logic [31:0] grant_cnt1,
   output logic [31:0] stall_cnt0,
   output logic [31:0] stall_cnt1
`endif
);

   arb_state_t            state;
   logic                  rr_ptr;
   logic [LOCK_CNT_W-1:0] lock_cnt;
   logic [1:0]            owner;
   logic [1:0]            pick;
   logic                  in_range0;
   logic                  in_range1;

   assign in_range0 = word_in_range(addr0, DATA_MEM_SIZE);
   assign in_range1 = word_in_range(addr1, DATA_MEM_SIZE);

   assign owner = (state == OWN0) ? 2'b01 :
                  (state == OWN1) ? 2'b10 : 2'b00;

   dmem_rr_pick u_pick (
      .req    ({req1, req0}),
      .rr_ptr (rr_ptr),
      .owner  (owner),
      .gnt    (pick)
   );

   // Grants are combinational, so they must be gated by reset directly.
   assign gnt0 = pick[0] & ~rst;
   assign gnt1 = pick[1] & ~rst;

   assign mem_addr       = gnt1 ? addr1  : addr0;
   assign mem_write_data = gnt1 ? wdata1 : wdata0;
   assign mem_write      = (gnt0 & we0 & in_range0) | (gnt1 & we1 & in_range1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ARB;
         rr_ptr       <= 1'b0;
         lock_cnt     <= '0;
         lock_timeout <= 1'b0;
         rvalid0      <= 1'b0;
         rvalid1      <= 1'b0;
         err0         <= 1'b0;
         err1         <= 1'b0;
         rdata0       <= '0;
         rdata1       <= '0;
      end else begin
         lock_timeout <= 1'b0;
         rvalid0      <= gnt0 & ~we0;
         rvalid1      <= gnt1 & ~we1;
         err0         <= gnt0 & ~in_range0;
         err1         <= gnt1 & ~in_range1;
         if (gnt0 && !we0)
            rdata0 <= in_range0 ? mem_read_data : 32'd0;
         if (gnt1 && !we1)
            rdata1 <= in_range1 ? mem_read_data : 32'd0;

         case (state)
            ARB: begin
               if (gnt0) begin
                  rr_ptr <= 1'b1;
                  if (lock0) begin
                     state    <= OWN0;
                     lock_cnt <= '0;
                  end
               end else if (gnt1) begin
                  rr_ptr <= 1'b0;
                  if (lock1) begin
                     state    <= OWN1;
                     lock_cnt <= '0;
                  end
               end
            end
            OWN0: begin
               lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
               if (!lock0) begin
                  state  <= ARB;
                  rr_ptr <= 1'b1;
               end else if (lock_cnt == LOCK_CNT_W'(MAX_LOCK - 1)) begin
                  state        <= ARB;
                  rr_ptr       <= 1'b1;
                  lock_timeout <= 1'b1;
               end
            end
            OWN1: begin
               lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
               if (!lock1) begin
                  state  <= ARB;
                  rr_ptr <= 1'b0;
               end else if (lock_cnt == LOCK_CNT_W'(MAX_LOCK - 1)) begin
                  state        <= ARB;
                  rr_ptr       <= 1'b0;
                  lock_timeout <= 1'b1;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt0 <= '0;
         stall_cnt1 <= '0;
      end else begin
         if (gnt0 && grant_cnt0 != 32'hFFFF_FFFF)
            grant_cnt0 <= grant_cnt0 + 32'd1;
         if (gnt1 && grant_cnt1 != 32'hFFFF_FFFF)
            grant_cnt1 <= grant_cnt1 + 32'd1;
         if (req0 && !gnt0 && stall_cnt0 != 32'hFFFF_FFFF)
            stall_cnt0 <= stall_cnt0 + 32'd1;
         if (req1 && !gnt1 && stall_cnt1 != 32'hFFFF_FFFF)
            stall_cnt1 <= stall_cnt1 + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed self-checking bench with a 64-word combinational-read memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_write, lock_timeout;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] grant_cnt0, grant_cnt1, stall_cnt0, stall_cnt1;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_addr[7:2]];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++)
            mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (mem_write) begin
         mem[mem_addr[7:2]] <= mem_write_data;
      end
   end

   dmem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .req0           (req0),
      .req1           (req1),
      .we0            (we0),
      .we1            (we1),
      .lock0          (lock0),
      .lock1          (lock1),
      .addr0          (addr0),
      .addr1          (addr1),
      .wdata0         (wdata0),
      .wdata1         (wdata1),
      .gnt0           (gnt0),
      .gnt1           (gnt1),
      .rvalid0        (rvalid0),
      .rvalid1        (rvalid1),
      .rdata0         (rdata0),
      .rdata1         (rdata1),
      .err0           (err0),
      .err1           (err1),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data),
      .lock_timeout   (lock_timeout)
`ifdef DMEM_ARB_STATS_EN
      ,
      .grant_cnt0     (grant_cnt0),
      .grant_cnt1     (grant_cnt1),
      .stall_cnt0     (stall_cnt0),
      .stall_cnt1     (stall_cnt1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      addr0 = 32'h4; addr1 = 32'h8; wdata0 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_err0", err0, 0);
      check("rst_lock_timeout", lock_timeout, 0);
      rst = 1'b0;

      // Both ports read; rr_ptr=0 after reset favours port 0.
      #1;
      check("rr_gnt0", gnt0, 1);
      check("rr_gnt1", gnt1, 0);
      check("rr_mem_addr", mem_addr, 32'h4);
      tick();
      check("rr_rvalid0", rvalid0, 1);
      check("rr_rdata0", rdata0, 32'h1000_0001);
      req0 = 1'b0;
      #1;
      check("rr_gnt1_next", gnt1, 1);
      tick();
      check("rr_rvalid1", rvalid1, 1);
      check("rr_rdata1", rdata1, 32'h1000_0002);
      check("rr_rvalid0_drop", rvalid0, 0);
      check("rr_rdata0_hold", rdata0, 32'h1000_0001);
      req1 = 1'b0;

      // Write from port 0 then read the same word from port 1.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
      #1;
      check("raw_gnt0", gnt0, 1);
      check("raw_mem_write", mem_write, 1);
      check("raw_wdata", mem_write_data, 32'hDEAD_BEEF);
      tick();
      check("raw_wr_rvalid0", rvalid0, 0);
      req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; addr1 = 32'h10;
      #1;
      check("raw_gnt1", gnt1, 1);
      tick();
      check("raw_rvalid1", rvalid1, 1);
      check("raw_rdata1", rdata1, 32'hDEAD_BEEF);

      // Locked 4-word burst from port 1 while port 0 requests continuously.
      req0 = 1'b1; addr0 = 32'h0; req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h20;
      #1;
      check("bu_pre_gnt0", gnt0, 1);
      check("bu_pre_gnt1", gnt1, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         lock1 = (i < 3);
         addr1 = 32'h20 + 32'(4 * i);
         #1;
         check("bu_gnt0", gnt0, 0);
         check("bu_gnt1", gnt1, 1);
      end
      tick();
      check("bu_rdata1_last", rdata1, 32'h1000_000B);
      #1;
      check("bu_post_gnt0", gnt0, 1);
      check("bu_post_gnt1", gnt1, 0);

      // Port 1 holds its lock indefinitely and is force-released.
      tick();
      lock1 = 1'b1;
      #1;
      check("to_arb_gnt1", gnt1, 1);
      check("to_arb_gnt0", gnt0, 0);
      for (int i = 0; i < 16; i++) begin
         tick();
         #1;
         check("to_own_gnt0", gnt0, 0);
         check("to_own_gnt1", gnt1, 1);
         check("to_own_lock_timeout", lock_timeout, 0);
      end
      tick();
      #1;
      check("to_lock_timeout", lock_timeout, 1);
      check("to_rel_gnt0", gnt0, 1);
      check("to_rel_gnt1", gnt1, 0);
      tick();
      req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
      #1;
      check("to_lock_timeout_clr", lock_timeout, 0);

      // Out-of-range write and read at word index 64, then the last legal word.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'h1234_5678;
      #1;
      check("oor_wr_gnt0", gnt0, 1);
      check("oor_mem_write", mem_write, 0);
      tick();
      check("oor_wr_err0", err0, 1);
      check("oor_wr_rvalid0", rvalid0, 0);
      check("oor_mem_unchanged", mem[0], 32'h1000_0000);
      we0 = 1'b0;
      #1;
      tick();
      check("oor_rd_rvalid0", rvalid0, 1);
      check("oor_rd_err0", err0, 1);
      check("oor_rd_rdata0", rdata0, 32'h0);
      addr0 = 32'hFC;
      #1;
      tick();
      check("edge_rd_rdata0", rdata0, 32'h1000_003F);
      check("edge_rd_err0", err0, 0);
      check("edge_rd_rvalid0", rvalid0, 1);

      // Lock port 0, then reset asynchronously while it owns the memory.
      addr0 = 32'h0; lock0 = 1'b1;
      #1;
      tick();
      req1 = 1'b1;
      #1;
      check("own0_gnt1_blocked", gnt1, 0);
      check("own0_gnt0", gnt0, 1);
      check("own0_rvalid0", rvalid0, 1);
      rst = 1'b1;
      #1;
      check("arst_gnt0", gnt0, 0);
      check("arst_gnt1", gnt1, 0);
      check("arst_rvalid0", rvalid0, 0);
      check("arst_rdata0", rdata0, 32'h0);
      check("arst_mem_write", mem_write, 0);
      tick();
      rst = 1'b0; lock0 = 1'b0;
      #1;
      check("post_rst_gnt0", gnt0, 1);
      check("post_rst_gnt1", gnt1, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
